// File: rtl/pll_stream_reconfig_pkg.sv
// rtl/pll_stream_reconfig_pkg.sv - reconfig core addresses, PLL words, FSM states and error codes
package pll_stream_reconfig_pkg;

    // Reconfig core word addresses
    localparam logic [5:0] ADDR_MODE   = 6'h00;
    localparam logic [5:0] ADDR_STATUS = 6'h01;
    localparam logic [5:0] ADDR_START  = 6'h02;
    localparam logic [5:0] ADDR_N      = 6'h03;
    localparam logic [5:0] ADDR_M      = 6'h04;
    localparam logic [5:0] ADDR_C      = 6'h05;
    localparam logic [5:0] ADDR_K      = 6'h07;

    // Register payloads; counter words are {odd_duty, bypass, hi[7:0], lo[7:0]}
    localparam logic [31:0] MODE_POLLING      = 32'h0000_0001;
    localparam logic [31:0] START_GO          = 32'h0000_0001;
    localparam logic [31:0] M_WORD            = 32'h0000_0404;
    localparam logic [31:0] N_WORD            = 32'h0001_0000;
    localparam logic [31:0] K_WORD            = 32'hE8F5_C239;
    localparam logic [31:0] C0_WORD_1080P60   = 32'h0002_0201;
    localparam logic [31:0] C0_WORD_720P60    = 32'h0000_0303;
    localparam logic [31:0] STATUS_DONE_MASK  = 32'h0000_0001;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_MODE,
        ST_WR_M,
        ST_WR_N,
        ST_WR_C0,
        ST_WR_K,
        ST_WR_START,
        ST_POLL_RD,
        ST_SETTLE,
        ST_WAIT_LOCK,
        ST_DONE,
        ST_ERR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE         = 2'd0,
        ERR_POLL_TIMEOUT = 2'd1,
        ERR_LOCK_TIMEOUT = 2'd2
    } err_code_e;

    // C0 divider word for the selected timing (0 = 148.5 MHz, 1 = 74.25 MHz)
    function automatic logic [31:0] c0_word(input logic mode);
        return mode ? C0_WORD_720P60 : C0_WORD_1080P60;
    endfunction

endpackage

// File: rtl/pll_stream_reconfig_ctrl_if.sv
// rtl/pll_stream_reconfig_ctrl_if.sv - Avalon-MM management bus to the PLL reconfig core
interface pll_stream_reconfig_ctrl_if;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic        mgmt_read;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;

    modport master (
        output mgmt_address, mgmt_write, mgmt_read, mgmt_writedata,
        input  mgmt_readdata, mgmt_waitrequest
    );

    modport slave (
        input  mgmt_address, mgmt_write, mgmt_read, mgmt_writedata,
        output mgmt_readdata, mgmt_waitrequest
    );
endinterface

// File: rtl/pll_stream_reconfig_mm.sv
// rtl/pll_stream_reconfig_mm.sv - single-outstanding Avalon-MM master driven by a command port
module pll_stream_reconfig_mm (
    input  logic        refclk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic        cmd_write,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        cmd_done,
    output logic        cmd_pending,
    output logic [31:0] rdata,
    pll_stream_reconfig_ctrl_if.master mgmt
);
    logic        write_q;
    logic        read_q;
    logic [5:0]  addr_q;
    logic [31:0] data_q;

    // A transfer retires on the edge where its strobe is high and the slave is not stalling.
    assign cmd_done    = (write_q | read_q) & ~mgmt.mgmt_waitrequest;
    assign cmd_pending = write_q | read_q;
    assign rdata       = mgmt.mgmt_readdata;

    assign mgmt.mgmt_address   = addr_q;
    assign mgmt.mgmt_write     = write_q;
    assign mgmt.mgmt_read      = read_q;
    assign mgmt.mgmt_writedata = data_q;

    // Load a new command (may land on the retiring edge for back-to-back), otherwise hold until retired.
    always_ff @(posedge refclk) begin
        if (rst) begin
            write_q <= 1'b0;
            read_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (cmd_valid) begin
            write_q <= cmd_write;
            read_q  <= ~cmd_write;
            addr_q  <= cmd_addr;
            data_q  <= cmd_data;
        end else if (cmd_done) begin
            write_q <= 1'b0;
            read_q  <= 1'b0;
        end
    end
endmodule

// File: rtl/pll_stream_reconfig_ctrl.sv
// rtl/pll_stream_reconfig_ctrl.sv - sequencer retuning the pixel-clock PLL through the reconfig core
module pll_stream_reconfig_ctrl
    import pll_stream_reconfig_pkg::*;
#(
    parameter int LOCK_TIMEOUT  = 1_000_000,
    parameter int POLL_TIMEOUT  = 65_535,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       req,
    input  logic       mode_sel,
    input  logic       locked,
    pll_stream_reconfig_ctrl_if.master mgmt,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    output logic       cur_mode
);
    state_e      state_q;
    logic [31:0] cnt_q;
    logic        mode_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;
    err_code_e   err_code_q;
    logic        cur_mode_q;
    logic        lock_meta_q;
    logic        lock_sync_q;
    logic        poll_gap_q;

    logic        cmd_valid;
    logic        cmd_write;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_done;
    logic        cmd_pending;
    logic [31:0] mm_rdata;
    logic        status_done;
    logic        poll_to;
    logic        lock_to;
    logic        settle_end;

    assign status_done = (mm_rdata & STATUS_DONE_MASK) != '0;
    assign poll_to     = cnt_q == 32'(POLL_TIMEOUT);
    assign lock_to     = cnt_q == 32'(LOCK_TIMEOUT);
    assign settle_end  = cnt_q == 32'(SETTLE_CYCLES - 1);

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign err_code = err_code_q;
    assign cur_mode = cur_mode_q;

    pll_stream_reconfig_mm u_mm (
        .refclk      (refclk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_done    (cmd_done),
        .cmd_pending (cmd_pending),
        .rdata       (mm_rdata),
        .mgmt        (mgmt)
    );

    // Next Avalon command: issued on the edge the previous one retires so writes run back-to-back.
    always_comb begin
        cmd_valid = 1'b0;
        cmd_write = 1'b1;
        cmd_addr  = ADDR_MODE;
        cmd_data  = MODE_POLLING;
        case (state_q)
            ST_IDLE:     cmd_valid = req;
            ST_WR_MODE:  begin cmd_valid = cmd_done; cmd_addr = ADDR_M;     cmd_data = M_WORD;          end
            ST_WR_M:     begin cmd_valid = cmd_done; cmd_addr = ADDR_N;     cmd_data = N_WORD;          end
            ST_WR_N:     begin cmd_valid = cmd_done; cmd_addr = ADDR_C;     cmd_data = c0_word(mode_q); end
            ST_WR_C0:    begin cmd_valid = cmd_done; cmd_addr = ADDR_K;     cmd_data = K_WORD;          end
            ST_WR_K:     begin cmd_valid = cmd_done; cmd_addr = ADDR_START; cmd_data = START_GO;        end
            ST_WR_START: begin
                cmd_valid = cmd_done;
                cmd_write = 1'b0;
                cmd_addr  = ADDR_STATUS;
                cmd_data  = '0;
            end
            ST_POLL_RD:  begin
                cmd_valid = poll_gap_q & ~poll_to;
                cmd_write = 1'b0;
                cmd_addr  = ADDR_STATUS;
                cmd_data  = '0;
            end
            default:     cmd_valid = 1'b0;
        endcase
    end

    // Sequencer FSM with registered status outputs and the two-flop lock synchroniser.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
            cur_mode_q  <= 1'b0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            poll_gap_q  <= 1'b0;
        end else begin
            lock_meta_q <= locked;
            lock_sync_q <= lock_meta_q;
            done_q      <= 1'b0;
            case (state_q)
                ST_IDLE: if (req) begin
                    state_q    <= ST_WR_MODE;
                    busy_q     <= 1'b1;
                    mode_q     <= mode_sel;
                    error_q    <= 1'b0;
                    err_code_q <= ERR_NONE;
                end
                ST_WR_MODE: if (cmd_done) state_q <= ST_WR_M;
                ST_WR_M:    if (cmd_done) state_q <= ST_WR_N;
                ST_WR_N:    if (cmd_done) state_q <= ST_WR_C0;
                ST_WR_C0:   if (cmd_done) state_q <= ST_WR_K;
                ST_WR_K:    if (cmd_done) state_q <= ST_WR_START;
                ST_WR_START: if (cmd_done) begin
                    state_q    <= ST_POLL_RD;
                    cnt_q      <= '0;
                    poll_gap_q <= 1'b0;
                end
                ST_POLL_RD: begin
                    // Timeout wins over a status-done read landing on the same edge.
                    if (poll_to) begin
                        state_q    <= ST_ERR;
                        error_q    <= 1'b1;
                        err_code_q <= ERR_POLL_TIMEOUT;
                    end else if (cmd_done && status_done) begin
                        state_q <= ST_SETTLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q      <= cnt_q + 32'd1;
                        poll_gap_q <= cmd_done;
                    end
                end
                ST_SETTLE: begin
                    if (settle_end) begin
                        state_q <= ST_WAIT_LOCK;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_to) begin
                        state_q    <= ST_ERR;
                        error_q    <= 1'b1;
                        err_code_q <= ERR_LOCK_TIMEOUT;
                    end else if (lock_sync_q) begin
                        state_q    <= ST_DONE;
                        done_q     <= 1'b1;
                        cur_mode_q <= mode_q;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                ST_ERR: begin
                    // An in-flight read cannot be abandoned; leave only once the bus is quiet.
                    if (!cmd_pending || cmd_done) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pll_stream_reconfig_ctrl.sv
// tb/tb_pll_stream_reconfig_ctrl.sv - directed self-checking bench for pll_stream_reconfig_ctrl
module tb_pll_stream_reconfig_ctrl;
    logic       refclk = 1'b0;
    logic       rst, req, mode_sel, locked;
    logic       busy, done, error, cur_mode;
    logic [1:0] err_code;

    int errors = 0;
    int checks = 0;

    pll_stream_reconfig_ctrl_if mgmt_if ();

    pll_stream_reconfig_ctrl #(
        .LOCK_TIMEOUT  (50),
        .POLL_TIMEOUT  (20),
        .SETTLE_CYCLES (16)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .req      (req),
        .mode_sel (mode_sel),
        .locked   (locked),
        .mgmt     (mgmt_if),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code),
        .cur_mode (cur_mode)
    );

    always #10 refclk = ~refclk;

    // Slave model: stalls each write stall_cfg cycles; status reads return 0 zeros_cfg times, then 1.
    int stall_cfg  = 0;
    int zeros_cfg  = 0;
    bit never_done = 0;
    int stall_cnt  = 0;
    int rd_seen    = 0;

    assign mgmt_if.mgmt_waitrequest = mgmt_if.mgmt_write && (stall_cnt < stall_cfg);
    assign mgmt_if.mgmt_readdata = (mgmt_if.mgmt_read && mgmt_if.mgmt_address == 6'h01 &&
                                    !never_done && rd_seen >= zeros_cfg) ? 32'h1 : 32'h0;

    always @(posedge refclk) begin
        stall_cnt <= (mgmt_if.mgmt_write && mgmt_if.mgmt_waitrequest) ? stall_cnt + 1 : 0;
        if (mgmt_if.mgmt_write) rd_seen <= 0;
        else if (mgmt_if.mgmt_read && !mgmt_if.mgmt_waitrequest) rd_seen <= rd_seen + 1;
    end

    // Bus monitor: logs completed transfers, done pulses, stalls and stability under stall.
    int          cyc = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0, hold_viol = 0, stall_seen = 0;
    int          rd_cyc [0:15];
    logic [5:0]  wr_addr[0:15];
    logic [31:0] wr_data[0:15];
    logic        hold_pend = 1'b0;
    logic [5:0]  hold_addr;
    logic [31:0] hold_data;

    always @(posedge refclk) begin
        cyc = cyc + 1;
        if (hold_pend && (!mgmt_if.mgmt_write || mgmt_if.mgmt_address != hold_addr ||
                          mgmt_if.mgmt_writedata != hold_data))
            hold_viol = hold_viol + 1;
        hold_pend = mgmt_if.mgmt_write && mgmt_if.mgmt_waitrequest;
        hold_addr = mgmt_if.mgmt_address;
        hold_data = mgmt_if.mgmt_writedata;
        if (hold_pend) stall_seen = stall_seen + 1;
        if (mgmt_if.mgmt_write && !mgmt_if.mgmt_waitrequest) begin
            if (wr_cnt < 16) begin
                wr_addr[wr_cnt] = mgmt_if.mgmt_address;
                wr_data[wr_cnt] = mgmt_if.mgmt_writedata;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (mgmt_if.mgmt_read && !mgmt_if.mgmt_waitrequest) begin
            if (rd_cnt < 16) rd_cyc[rd_cnt] = cyc;
            rd_cnt = rd_cnt + 1;
        end
        if (done) done_cnt = done_cnt + 1;
    end

    function automatic logic [5:0] exp_addr(input int i);
        case (i)
            0: return 6'h00;
            1: return 6'h04;
            2: return 6'h03;
            3: return 6'h05;
            4: return 6'h07;
            default: return 6'h02;
        endcase
    endfunction

    function automatic logic [31:0] exp_data(input int i, input logic m);
        case (i)
            0: return 32'h0000_0001;
            1: return 32'h0000_0404;
            2: return 32'h0001_0000;
            3: return m ? 32'h0000_0303 : 32'h0002_0201;
            4: return 32'hE8F5_C239;
            default: return 32'h0000_0001;
        endcase
    endfunction

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic clear_log();
        wr_cnt = 0; rd_cnt = 0; done_cnt = 0; hold_viol = 0; stall_seen = 0;
    endtask

    // Leaves the caller one cycle after the accepting edge (first write cycle).
    task automatic pulse_req(input logic m);
        mode_sel = m;
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 400) begin tick(); n++; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle_timeout: busy=%b required 0", name, busy); end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; mode_sel = 1'b0; locked = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b required 0", error); end
        checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL rst_err_code: got %0d required 0", err_code); end
        checks++; if (cur_mode !== 1'b0) begin errors++; $display("FAIL rst_cur_mode: got %b required 0", cur_mode); end
        checks++; if (mgmt_if.mgmt_write !== 1'b0) begin errors++; $display("FAIL rst_write: got %b required 0", mgmt_if.mgmt_write); end
        checks++; if (mgmt_if.mgmt_read !== 1'b0) begin errors++; $display("FAIL rst_read: got %b required 0", mgmt_if.mgmt_read); end
        checks++; if (mgmt_if.mgmt_address !== 6'h0) begin errors++; $display("FAIL rst_address: got %0h required 0", mgmt_if.mgmt_address); end
        checks++; if (mgmt_if.mgmt_writedata !== 32'h0) begin errors++; $display("FAIL rst_writedata: got %0h required 0", mgmt_if.mgmt_writedata); end
    endtask

    task automatic test_basic_mode1();
        int n = 1;
        locked = 1'b1; stall_cfg = 0; zeros_cfg = 0; never_done = 0;
        repeat (4) tick();
        clear_log();
        pulse_req(1'b1);
        checks++; if (busy !== 1'b1 || mgmt_if.mgmt_write !== 1'b1 || mgmt_if.mgmt_address !== 6'h00) begin
            errors++; $display("FAIL basic_first_cycle: busy=%b write=%b addr=%0h required 1 1 0", busy, mgmt_if.mgmt_write, mgmt_if.mgmt_address); end
        while (!done && n < 200) begin tick(); n++; end
        checks++; if (n !== 25) begin errors++; $display("FAIL basic_done_cycle: got %0d required 25", n); end
        repeat (3) tick();
        checks++; if (wr_cnt !== 6) begin errors++; $display("FAIL basic_wr_cnt: got %0d required 6", wr_cnt); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (wr_addr[i] !== exp_addr(i) || wr_data[i] !== exp_data(i, 1'b1)) begin
                errors++; $display("FAIL basic_write%0d: got (%0h,%0h) required (%0h,%0h)", i, wr_addr[i], wr_data[i], exp_addr(i), exp_data(i, 1'b1)); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_cnt: got %0d required 1", done_cnt); end
        checks++; if (cur_mode !== 1'b1) begin errors++; $display("FAIL basic_cur_mode: got %b required 1", cur_mode); end
        checks++; if (busy !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL basic_end_state: busy=%b error=%b required 0 0", busy, error); end
    endtask

    task automatic test_stall_poll();
        stall_cfg = 3; zeros_cfg = 2; never_done = 0; locked = 1'b1;
        clear_log();
        pulse_req(1'b0);
        wait_idle("stall");
        checks++; if (stall_seen !== 18) begin errors++; $display("FAIL stall_cycles: got %0d required 18", stall_seen); end
        checks++; if (hold_viol !== 0) begin errors++; $display("FAIL stall_hold: got %0d changes required 0", hold_viol); end
        checks++; if (wr_cnt !== 6) begin errors++; $display("FAIL stall_wr_cnt: got %0d required 6", wr_cnt); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (wr_addr[i] !== exp_addr(i) || wr_data[i] !== exp_data(i, 1'b0)) begin
                errors++; $display("FAIL stall_write%0d: got (%0h,%0h) required (%0h,%0h)", i, wr_addr[i], wr_data[i], exp_addr(i), exp_data(i, 1'b0)); end
        end
        checks++; if (rd_cnt !== 3) begin errors++; $display("FAIL stall_rd_cnt: got %0d required 3", rd_cnt); end
        checks++; if (rd_cyc[1] - rd_cyc[0] !== 2 || rd_cyc[2] - rd_cyc[1] !== 2) begin
            errors++; $display("FAIL stall_rd_gap: got %0d,%0d required 2,2", rd_cyc[1] - rd_cyc[0], rd_cyc[2] - rd_cyc[1]); end
        checks++; if (done_cnt !== 1 || error !== 1'b0) begin errors++; $display("FAIL stall_success: done_cnt=%0d error=%b required 1 0", done_cnt, error); end
        checks++; if (cur_mode !== 1'b0) begin errors++; $display("FAIL stall_cur_mode: got %b required 0", cur_mode); end
        stall_cfg = 0; zeros_cfg = 0;
    endtask

    task automatic test_poll_timeout();
        never_done = 1; locked = 1'b1;
        clear_log();
        pulse_req(1'b1);
        wait_idle("poll_to");
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL poll_to_error: got %b required 1", error); end
        checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL poll_to_code: got %0d required 1", err_code); end
        checks++; if (cur_mode !== 1'b0) begin errors++; $display("FAIL poll_to_cur_mode: got %b required 0", cur_mode); end
        checks++; if (rd_cnt !== 11) begin errors++; $display("FAIL poll_to_reads: got %0d required 11", rd_cnt); end
        checks++; if (done_cnt !== 0 || mgmt_if.mgmt_read !== 1'b0) begin
            errors++; $display("FAIL poll_to_quiet: done_cnt=%0d read=%b required 0 0", done_cnt, mgmt_if.mgmt_read); end
        never_done = 0;
    endtask

    task automatic test_lock_timeout();
        locked = 1'b0;
        repeat (4) tick();
        clear_log();
        pulse_req(1'b1);
        wait_idle("lock_to");
        checks++; if (error !== 1'b1 || err_code !== 2'd2) begin
            errors++; $display("FAIL lock_to_code: error=%b code=%0d required 1 2", error, err_code); end
        checks++; if (cur_mode !== 1'b0 || done_cnt !== 0) begin
            errors++; $display("FAIL lock_to_mode: cur_mode=%b done_cnt=%0d required 0 0", cur_mode, done_cnt); end
        locked = 1'b1;
        repeat (3) tick();
        clear_log();
        pulse_req(1'b1);
        checks++; if (error !== 1'b0 || err_code !== 2'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL lock_retry_clear: error=%b code=%0d busy=%b required 0 0 1", error, err_code, busy); end
        wait_idle("lock_retry");
        checks++; if (done_cnt !== 1 || cur_mode !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL lock_retry_ok: done_cnt=%0d cur_mode=%b error=%b required 1 1 0", done_cnt, cur_mode, error); end
    endtask

    task automatic test_back_to_back();
        locked = 1'b1;
        clear_log();
        pulse_req(1'b0);
        repeat (2) tick();
        mode_sel = 1'b1; req = 1'b1;
        tick();
        req = 1'b0;
        wait_idle("b2b");
        repeat (10) tick();
        checks++; if (wr_cnt !== 6) begin errors++; $display("FAIL b2b_wr_cnt: got %0d required 6", wr_cnt); end
        checks++; if (wr_data[3] !== 32'h0002_0201) begin errors++; $display("FAIL b2b_c0: got %0h required 20201", wr_data[3]); end
        checks++; if (done_cnt !== 1 || cur_mode !== 1'b0) begin
            errors++; $display("FAIL b2b_done: done_cnt=%0d cur_mode=%b required 1 0", done_cnt, cur_mode); end
    endtask

    task automatic test_lock_boundary();
        // Synchronised lock first seen on the timeout cycle: error wins.
        locked = 1'b0;
        repeat (4) tick();
        clear_log();
        pulse_req(1'b1);
        repeat (71) tick();
        locked = 1'b1;
        repeat (3) tick();
        checks++; if (error !== 1'b1 || err_code !== 2'd2) begin
            errors++; $display("FAIL coincide_error: error=%b code=%0d required 1 2", error, err_code); end
        wait_idle("coincide");
        checks++; if (done_cnt !== 0 || cur_mode !== 1'b0) begin
            errors++; $display("FAIL coincide_mode: done_cnt=%0d cur_mode=%b required 0 0", done_cnt, cur_mode); end
        // One cycle earlier the lock is accepted.
        locked = 1'b0;
        repeat (4) tick();
        clear_log();
        pulse_req(1'b1);
        repeat (70) tick();
        locked = 1'b1;
        repeat (3) tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL lock_edge_done: got %b required 1", done); end
        wait_idle("lock_edge");
        checks++; if (error !== 1'b0 || cur_mode !== 1'b1) begin
            errors++; $display("FAIL lock_edge_ok: error=%b cur_mode=%b required 0 1", error, cur_mode); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        stall_cfg = 3; locked = 1'b1;
        clear_log();
        pulse_req(1'b0);
        while (!(mgmt_if.mgmt_write && mgmt_if.mgmt_address == 6'h05) && n < 60) begin tick(); n++; end
        checks++; if (n >= 60) begin errors++; $display("FAIL rmid_reach_c0: got %0d cycles required <60", n); end
        tick();
        rst = 1'b1;
        tick();
        checks++; if (mgmt_if.mgmt_write !== 1'b0 || mgmt_if.mgmt_read !== 1'b0) begin
            errors++; $display("FAIL rmid_strobes: write=%b read=%b required 0 0", mgmt_if.mgmt_write, mgmt_if.mgmt_read); end
        checks++; if (mgmt_if.mgmt_address !== 6'h0 || mgmt_if.mgmt_writedata !== 32'h0) begin
            errors++; $display("FAIL rmid_bus: addr=%0h data=%0h required 0 0", mgmt_if.mgmt_address, mgmt_if.mgmt_writedata); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || err_code !== 2'd0 || cur_mode !== 1'b0) begin
            errors++; $display("FAIL rmid_status: busy=%b done=%b error=%b code=%0d cur_mode=%b required all 0", busy, done, error, err_code, cur_mode); end
        rst = 1'b0;
        stall_cfg = 0;
        tick();
        clear_log();
        pulse_req(1'b1);
        wait_idle("rmid_rerun");
        checks++; if (wr_cnt !== 6) begin errors++; $display("FAIL rmid_wr_cnt: got %0d required 6", wr_cnt); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (wr_addr[i] !== exp_addr(i) || wr_data[i] !== exp_data(i, 1'b1)) begin
                errors++; $display("FAIL rmid_write%0d: got (%0h,%0h) required (%0h,%0h)", i, wr_addr[i], wr_data[i], exp_addr(i), exp_data(i, 1'b1)); end
        end
        checks++; if (done_cnt !== 1 || cur_mode !== 1'b1) begin
            errors++; $display("FAIL rmid_done: done_cnt=%0d cur_mode=%b required 1 1", done_cnt, cur_mode); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_mode1();
        test_stall_poll();
        test_poll_timeout();
        test_lock_timeout();
        test_back_to_back();
        test_lock_boundary();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
